mdio_phy_responder: RTL and testbench

PHY-side Clause 22 MDIO responder: the slave end of the management link driven by the core's `mdio_if` master. Oversamples MDC/MDIO on the 125 MHz system clock, decodes read/write frames addressed to its PHY address, and serves a 32×16 register file. Sits in simulation benches and in loopback builds in place of a real PHY, so the MDIO master path can be exercised without hardware.

---
 rtl/mdio_phy_responder_pkg.sv | 16 +
 rtl/mdio_phy_responder_regfile.sv | 44 ++++
 rtl/mdio_phy_responder.sv | 183 ++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_phy_responder_pkg.sv
// mdio_phy_responder_pkg: shared MDIO Clause 22 constants, FSM states and register helpers.
package mdio_phy_responder_pkg;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;
  localparam logic [4:0] REG_BMCR   = 5'd0;
  localparam logic [4:0] REG_BMSR   = 5'd1;
  localparam logic [4:0] REG_PHYID1 = 5'd2;
  localparam logic [4:0] REG_PHYID2 = 5'd3;
  typedef enum logic [2:0] {S_HUNT, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA} state_e;
  function automatic logic is_ro(input logic [4:0] a);
    return a == REG_BMSR || a == REG_PHYID1 || a == REG_PHYID2;
  endfunction
endpackage

// File: rtl/mdio_phy_responder_regfile.sv
// mdio_regfile: 32x16 PHY register file with constant ID/status regs and BMCR soft reset.
module mdio_regfile
  import mdio_phy_responder_pkg::*;
#(
  parameter logic [15:0] REG0_RST = 16'h1140,
  parameter logic [15:0] REG1_VAL = 16'h796D,
  parameter logic [15:0] PHYID1   = 16'h0022,
  parameter logic [15:0] PHYID2   = 16'h1622
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data
);
  logic [15:0] mem_q [32];
  logic [15:0] mem_d [32];
  always_comb begin
    mem_d = mem_q;
    if (we && !is_ro(wr_addr)) begin
      if (wr_addr == REG_BMCR && wr_data[15]) begin
        for (int i = 0; i < 32; i++) mem_d[i] = '0;
        mem_d[0] = REG0_RST;
      end else begin
        mem_d[wr_addr] = wr_data;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
      mem_q[0] <= REG0_RST;
    end else begin
      mem_q <= mem_d;
    end
  end
  // BMCR bit 15 is self-clearing, so it never reads back as 1
  assign rd_data = rd_addr == REG_BMSR   ? REG1_VAL :
                   rd_addr == REG_PHYID1 ? PHYID1 :
                   rd_addr == REG_PHYID2 ? PHYID2 :
                   rd_addr == REG_BMCR   ? {1'b0, mem_q[0][14:0]} : mem_q[rd_addr];
endmodule

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause 22 MDIO slave, oversamples MDC/MDIO on clk and serves a 32x16 regfile.
module mdio_phy_responder
  import mdio_phy_responder_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'b00100,
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] REG0_RST     = 16'h1140,
  parameter logic [15:0] REG1_VAL     = 16'h796D,
  parameter logic [15:0] PHYID1       = 16'h0022,
  parameter logic [15:0] PHYID2       = 16'h1622
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        frame_error
);
  localparam int PW = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_MIN);
  state_e state_q, state_d;
  logic [2:0] mdc_sync_q, mdc_sync_d;
  logic [1:0] mdio_sync_q, mdio_sync_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [4:0] cnt_q, cnt_d, phy_q, phy_d, ra_q, ra_d, wa_q, wa_d;
  logic [15:0] sh_q, sh_d, wd_q, wd_d, rd_data;
  logic rd_q, rd_d, o_q, o_d, t_q, t_d, wv_q, wv_d, err_q, err_d, we;
  logic rise, b;
  assign rise = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign b = mdio_sync_q[1];
  always_comb begin
    mdc_sync_d = {mdc_sync_q[1:0], mdc};
    mdio_sync_d = {mdio_sync_q[0], mdio_i};
    state_d = state_q;
    pre_d = pre_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    phy_d = phy_q;
    ra_d = ra_q;
    sh_d = sh_q;
    o_d = o_q;
    t_d = t_q;
    wv_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    err_d = 1'b0;
    we = 1'b0;
    if (rise) begin
      unique case (state_q)
        S_HUNT: begin
          pre_d = b ? (pre_q == PRE_MAX ? pre_q : pre_q + 1'b1) : '0;
          if (!b && pre_q == PRE_MAX) state_d = S_ST;
        end
        S_ST: begin
          state_d = b ? S_OP : S_HUNT;
          err_d = !b;
          cnt_d = 5'd1;
        end
        S_OP: begin
          sh_d = {sh_q[14:0], b};
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            rd_d = {sh_q[0], b} == MDIO_OP_READ;
            if ({sh_q[0], b} == MDIO_OP_READ || {sh_q[0], b} == MDIO_OP_WRITE) begin
              state_d = S_PHYAD;
              cnt_d = 5'd4;
            end else begin
              state_d = S_HUNT;
              err_d = 1'b1;
            end
          end
        end
        S_PHYAD: begin
          phy_d = {phy_q[3:0], b};
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d = S_REGAD;
            cnt_d = 5'd4;
          end
        end
        S_REGAD: begin
          ra_d = {ra_q[3:0], b};
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d = phy_q == PHY_ADDR ? S_TA : S_HUNT;
            cnt_d = 5'd1;
            if (rd_q) sh_d = rd_data;
          end
        end
        S_TA: begin
          cnt_d = cnt_q - 5'd1;
          if (rd_q) begin
            if (cnt_q == 5'd1) begin
              t_d = 1'b0;
              o_d = 1'b0;
            end else begin
              o_d = sh_q[15];
              sh_d = sh_q << 1;
              state_d = S_DATA;
              cnt_d = 5'd15;
            end
          end else if (b != cnt_q[0]) begin
            // write turnaround must be 1 then 0
            state_d = S_HUNT;
            err_d = 1'b1;
          end else if (cnt_q == 5'd0) begin
            state_d = S_DATA;
            cnt_d = 5'd15;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q - 5'd1;
          if (rd_q) begin
            o_d = cnt_q == 5'd0 ? 1'b1 : sh_q[15];
            t_d = cnt_q == 5'd0;
            sh_d = sh_q << 1;
          end else begin
            sh_d = {sh_q[14:0], b};
          end
          if (cnt_q == 5'd0) begin
            state_d = S_HUNT;
            we = !rd_q;
            wv_d = !rd_q && !is_ro(ra_q);
            wa_d = wv_d ? ra_q : wa_q;
            wd_d = wv_d ? {sh_q[14:0], b} : wd_q;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HUNT;
      mdc_sync_q <= '0;
      mdio_sync_q <= '0;
      pre_q <= '0;
      cnt_q <= '0;
      rd_q <= 1'b0;
      phy_q <= '0;
      ra_q <= '0;
      sh_q <= '0;
      o_q <= 1'b1;
      t_q <= 1'b1;
      wv_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mdc_sync_q <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      phy_q <= phy_d;
      ra_q <= ra_d;
      sh_q <= sh_d;
      o_q <= o_d;
      t_q <= t_d;
      wv_q <= wv_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      err_q <= err_d;
    end
  end
  mdio_regfile #(
    .REG0_RST(REG0_RST), .REG1_VAL(REG1_VAL), .PHYID1(PHYID1), .PHYID2(PHYID2)
  ) u_regfile (
    .clk(clk), .rst(rst), .we(we), .wr_addr(ra_q), .wr_data({sh_q[14:0], b}),
    .rd_addr({ra_q[3:0], b}), .rd_data(rd_data)
  );
  assign mdio_o = o_q;
  assign mdio_t = t_q;
  assign reg_wr_valid = wv_q;
  assign reg_wr_addr = wa_q;
  assign reg_wr_data = wd_q;
  assign frame_error = err_q;
endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder: drives MDIO master frames and checks against a register-map model.
module tb_mdio_phy_responder;
  localparam int H = 8;
  logic clk = 1'b0, rst, mdc, mdio_i;
  logic mdio_o, mdio_t, reg_wr_valid, frame_error;
  logic [4:0] reg_wr_addr;
  logic [15:0] reg_wr_data;
  int checks = 0, errors = 0, wr_cnt = 0, err_cnt = 0;
  logic [4:0] last_wa;
  logic [15:0] last_wd;
  logic [15:0] model [32];

  mdio_phy_responder dut (
    .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t),
    .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .frame_error(frame_error)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr_valid) begin
      wr_cnt++;
      last_wa = reg_wr_addr;
      last_wd = reg_wr_data;
    end
    if (frame_error) err_cnt++;
  end

  task automatic m_reset();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    model[0] = 16'h1140;
  endtask

  function automatic logic [15:0] m_read(input logic [4:0] a);
    if (a == 5'd1) return 16'h796D;
    if (a == 5'd2) return 16'h0022;
    if (a == 5'd3) return 16'h1622;
    if (a == 5'd0) return model[0] & 16'h7FFF;
    return model[a];
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [15:0] d);
    if (a >= 5'd1 && a <= 5'd3) return;
    if (a == 5'd0 && d[15]) m_reset();
    else model[a] = d;
  endtask

  // line/drv are MSB-first over the 32 post-preamble bits, sampled just before each MDC rise
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [1:0] ta, input logic [15:0] wd, input int abort_at,
                       output logic [31:0] line, output logic [31:0] drv);
    logic [31:0] bits;
    bits = {2'b01, op, phy, ra, ta, wd};
    line = '0;
    drv = '0;
    for (int i = 0; i < pre + 32; i++) begin
      mdio_i = i < pre ? 1'b1 : bits[31 - (i - pre)];
      repeat (H) @(negedge clk);
      if (i >= pre) begin
        line[31 - (i - pre)] = mdio_t ? 1'b1 : mdio_o;
        drv[31 - (i - pre)] = !mdio_t;
        if (i - pre == abort_at) return;
      end
      mdc = 1'b1;
      repeat (H) @(negedge clk);
      mdc = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
    logic [31:0] l, dv;
    frame(32, 2'b01, phy, ra, 2'b10, d, -1, l, dv);
  endtask

  task automatic rd(input logic [4:0] phy, input logic [4:0] ra, output logic [31:0] l, output logic [31:0] dv);
    frame(32, 2'b10, phy, ra, 2'b11, 16'hFFFF, -1, l, dv);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mdc = 1'b0;
    mdio_i = 1'b1;
    m_reset();
    repeat (4) @(negedge clk);
    checks++;
    if ({mdio_t, mdio_o, reg_wr_valid, reg_wr_addr, reg_wr_data, frame_error} !== {3'b110, 5'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: t=%b o=%b v=%b a=%h d=%h e=%b, expected t=1 o=1 v=0 a=0 d=0 e=0",
               mdio_t, mdio_o, reg_wr_valid, reg_wr_addr, reg_wr_data, frame_error);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_read();
    int w0;
    logic [31:0] l, dv;
    w0 = wr_cnt;
    wr(5'd4, 5'd4, 16'hA5A5);
    m_write(5'd4, 16'hA5A5);
    checks++;
    if (wr_cnt - w0 !== 1 || last_wa !== 5'd4 || last_wd !== 16'hA5A5) begin
      errors++;
      $display("FAIL write_pulse: pulses=%0d addr=%h data=%h, expected 1 04 a5a5", wr_cnt - w0, last_wa, last_wd);
    end
    rd(5'd4, 5'd4, l, dv);
    checks++;
    if (l[15:0] !== m_read(5'd4)) begin
      errors++;
      $display("FAIL read_back: got %h expected %h", l[15:0], m_read(5'd4));
    end
    checks++;
    if (dv !== 32'h0001FFFF || mdio_t !== 1'b1) begin
      errors++;
      $display("FAIL read_drive_window: drv=%h t_after=%b expected 0001ffff 1", dv, mdio_t);
    end
  endtask

  task automatic test_read_only();
    int w0;
    logic [31:0] l, dv;
    rd(5'd4, 5'd2, l, dv);
    checks++;
    if (l[15:0] !== 16'h0022 || l[16] !== 1'b0) begin
      errors++;
      $display("FAIL phyid1_read: data=%h ta2=%b expected 0022 0", l[15:0], l[16]);
    end
    w0 = wr_cnt;
    wr(5'd4, 5'd2, 16'hFFFF);
    m_write(5'd2, 16'hFFFF);
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL ro_no_pulse: pulses=%0d expected 0", wr_cnt - w0);
    end
    rd(5'd4, 5'd2, l, dv);
    checks++;
    if (l[15:0] !== m_read(5'd2)) begin
      errors++;
      $display("FAIL ro_reread: got %h expected %h", l[15:0], m_read(5'd2));
    end
  endtask

  task automatic test_other_phy();
    int w0, e0;
    logic [31:0] l, dv;
    w0 = wr_cnt;
    e0 = err_cnt;
    rd(5'd5, 5'd4, l, dv);
    checks++;
    if (dv !== 32'h0) begin
      errors++;
      $display("FAIL other_phy_drive: drv=%h expected 00000000", dv);
    end
    wr(5'd5, 5'd6, 16'h1234);
    checks++;
    if (wr_cnt !== w0 || err_cnt !== e0) begin
      errors++;
      $display("FAIL other_phy_pulse: wr=%0d err=%0d expected 0 0", wr_cnt - w0, err_cnt - e0);
    end
  endtask

  task automatic test_errors();
    int w0, e0;
    logic [31:0] l, dv;
    w0 = wr_cnt;
    e0 = err_cnt;
    frame(31, 2'b01, 5'd4, 5'd7, 2'b10, 16'h1234, -1, l, dv);
    checks++;
    if (wr_cnt !== w0 || err_cnt !== e0) begin
      errors++;
      $display("FAIL short_preamble: wr=%0d err=%0d expected 0 0", wr_cnt - w0, err_cnt - e0);
    end
    frame(32, 2'b11, 5'd4, 5'd8, 2'b10, 16'h4321, -1, l, dv);
    checks++;
    if (wr_cnt !== w0 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL bad_op: wr=%0d err=%0d expected 0 1", wr_cnt - w0, err_cnt - e0);
    end
    frame(32, 2'b01, 5'd4, 5'd8, 2'b11, 16'h4321, -1, l, dv);
    checks++;
    if (wr_cnt !== w0 || err_cnt - e0 !== 2) begin
      errors++;
      $display("FAIL bad_ta: wr=%0d err=%0d expected 0 2", wr_cnt - w0, err_cnt - e0);
    end
    wr(5'd4, 5'd8, 16'h5AA5);
    m_write(5'd8, 16'h5AA5);
    rd(5'd4, 5'd7, l, dv);
    checks++;
    if (l[15:0] !== m_read(5'd7)) begin
      errors++;
      $display("FAIL ignored_write_reg7: got %h expected %h", l[15:0], m_read(5'd7));
    end
    rd(5'd4, 5'd8, l, dv);
    checks++;
    if (l[15:0] !== m_read(5'd8) || wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL recover_after_error: got %h pulses=%0d expected %h 1", l[15:0], wr_cnt - w0, m_read(5'd8));
    end
  endtask

  task automatic test_soft_reset();
    logic [31:0] l, dv;
    wr(5'd4, 5'd4, 16'h1234);
    m_write(5'd4, 16'h1234);
    wr(5'd4, 5'd0, 16'h8000);
    m_write(5'd0, 16'h8000);
    checks++;
    if (last_wa !== 5'd0 || last_wd !== 16'h8000) begin
      errors++;
      $display("FAIL soft_reset_pulse: addr=%h data=%h expected 00 8000", last_wa, last_wd);
    end
    rd(5'd4, 5'd0, l, dv);
    checks++;
    if (l[15:0] !== m_read(5'd0)) begin
      errors++;
      $display("FAIL soft_reset_reg0: got %h expected %h", l[15:0], m_read(5'd0));
    end
    rd(5'd4, 5'd4, l, dv);
    checks++;
    if (l[15:0] !== m_read(5'd4)) begin
      errors++;
      $display("FAIL soft_reset_reg4: got %h expected %h", l[15:0], m_read(5'd4));
    end
  endtask

  task automatic test_random();
    logic [31:0] l, dv;
    logic [4:0] phy, ra;
    logic [15:0] d;
    int w0;
    for (int n = 0; n < 14; n++) begin
      phy = $urandom_range(0, 3) == 0 ? 5'($urandom_range(5, 31)) : 5'd4;
      ra = 5'($urandom_range(0, 31));
      d = 16'($urandom) & 16'h7FFF;
      w0 = wr_cnt;
      if ($urandom_range(0, 1) == 1) begin
        wr(phy, ra, d);
        if (phy == 5'd4) m_write(ra, d);
        checks++;
        if (wr_cnt - w0 !== ((phy == 5'd4 && !(ra >= 5'd1 && ra <= 5'd3)) ? 1 : 0)) begin
          errors++;
          $display("FAIL rand_write: phy=%h reg=%h pulses=%0d", phy, ra, wr_cnt - w0);
        end
      end else begin
        rd(phy, ra, l, dv);
        checks++;
        if (phy == 5'd4 ? (l[15:0] !== m_read(ra) || dv !== 32'h0001FFFF) : dv !== 32'h0) begin
          errors++;
          $display("FAIL rand_read: phy=%h reg=%h got %h drv=%h expected %h", phy, ra, l[15:0], dv, m_read(ra));
        end
      end
    end
  endtask

  task automatic test_rst_mid_read();
    logic [31:0] l, dv;
    wr(5'd4, 5'd9, 16'h0F0F);
    m_write(5'd9, 16'h0F0F);
    frame(32, 2'b10, 5'd4, 5'd9, 2'b11, 16'hFFFF, 24, l, dv);
    checks++;
    if (mdio_t !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_driving: t=%b expected 0", mdio_t);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mdio_t !== 1'b1 || mdio_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_release: t=%b o=%b expected 1 1", mdio_t, mdio_o);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    rd(5'd4, 5'd0, l, dv);
    checks++;
    if (l[15:0] !== m_read(5'd0) || dv !== 32'h0001FFFF) begin
      errors++;
      $display("FAIL after_rst_read: got %h drv=%h expected %h", l[15:0], dv, m_read(5'd0));
    end
    rd(5'd4, 5'd9, l, dv);
    checks++;
    if (l[15:0] !== m_read(5'd9)) begin
      errors++;
      $display("FAIL after_rst_reg9: got %h expected %h", l[15:0], m_read(5'd9));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_only();
    test_other_phy();
    test_errors();
    test_soft_reset();
    test_random();
    test_rst_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
